// File: rtl/median_filter_3x3_rgb565_pkg.sv
// Purpose: shared constants and RGB565 channel types for the 3x3 median filter.
// Latency: n/a (package only).
// Backpressure: n/a; the filter has none, it streams one pixel per clock.
// Contents: channel field positions, pipeline depth, channel typedefs.
package median_pkg;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   // S1 row sort, S2 column selections, S3 final median.
   localparam int MEDIAN_LATENCY = 3;

   typedef logic [R_MSB-R_LSB:0] r_chan_t;
   typedef logic [G_MSB-G_LSB:0] g_chan_t;
   typedef logic [B_MSB-B_LSB:0] b_chan_t;

   typedef struct packed {
      r_chan_t r;
      g_chan_t g;
      b_chan_t b;
   } rgb565_t;

endpackage

// File: rtl/median_filter_3x3_rgb565_sort3.sv
// Purpose: registered three-input sorter, the building block of the median network.
// Latency: 1 clk from a/b/c to max/mid/min.
// Backpressure: none; advances every clock.
// Ports: clk, rst_n (async active-low), a/b/c [W-1:0] in, max/mid/min [W-1:0] out (reset 0).
module sort3 #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] max,
   output logic [W-1:0] mid,
   output logic [W-1:0] min
);

   logic [W-1:0] max_nxt, mid_nxt, min_nxt;

   // Ties resolve to an arbitrary equal input, which is the same value.
   always_comb begin
      max_nxt = a;
      mid_nxt = b;
      min_nxt = c;
      if (a >= b) begin
         if (b >= c) begin
            max_nxt = a; mid_nxt = b; min_nxt = c;
         end else if (a >= c) begin
            max_nxt = a; mid_nxt = c; min_nxt = b;
         end else begin
            max_nxt = c; mid_nxt = a; min_nxt = b;
         end
      end else begin
         if (a >= c) begin
            max_nxt = b; mid_nxt = a; min_nxt = c;
         end else if (b >= c) begin
            max_nxt = b; mid_nxt = c; min_nxt = a;
         end else begin
            max_nxt = c; mid_nxt = b; min_nxt = a;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max <= '0;
         mid <= '0;
         min <= '0;
      end else begin
         max <= max_nxt;
         mid <= mid_nxt;
         min <= min_nxt;
      end
   end

endmodule

// File: rtl/median_filter_3x3_rgb565.sv
// Purpose: per-channel 3x3 median of an RGB565 window, sync signals re-aligned.
// Latency: 3 clk for data and vsync/hsync/clken alike.
// Backpressure: none; datapath shifts every clock, post_frame_clken qualifies data.
// Ports: clk, rst_n, matrix_frame_{vsync,hsync,clken}, matrix_11..matrix_33 (row 1 oldest,
//        column 3 newest) in; post_frame_{vsync,hsync,clken}, post_img_data out.
// Option: MEDIAN_BORDER_PASS_EN passes the raw centre for the first two pixels of a line.
module median_filter_3x3_rgb565
   import median_pkg::*;
#(
   parameter int IMG_HDISP = 640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        matrix_frame_vsync,
   input  logic        matrix_frame_hsync,
   input  logic        matrix_frame_clken,
   input  logic [15:0] matrix_11,
   input  logic [15:0] matrix_12,
   input  logic [15:0] matrix_13,
   input  logic [15:0] matrix_21,
   input  logic [15:0] matrix_22,
   input  logic [15:0] matrix_23,
   input  logic [15:0] matrix_31,
   input  logic [15:0] matrix_32,
   input  logic [15:0] matrix_33,
   output logic        post_frame_vsync,
   output logic        post_frame_hsync,
   output logic        post_frame_clken,
   output logic [15:0] post_img_data
);

   // A 3x3 window needs at least three pixels per line.
   if (IMG_HDISP < 3) begin : g_hdisp_too_small
      $error("IMG_HDISP must be at least 3");
   end

   logic [15:0] tap [9];
   logic [15:0] median_dat;

   assign tap[0] = matrix_11;
   assign tap[1] = matrix_12;
   assign tap[2] = matrix_13;
   assign tap[3] = matrix_21;
   assign tap[4] = matrix_22;
   assign tap[5] = matrix_23;
   assign tap[6] = matrix_31;
   assign tap[7] = matrix_32;
   assign tap[8] = matrix_33;

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      localparam int MSB = (ch == 0) ? R_MSB : (ch == 1) ? G_MSB : B_MSB;
      localparam int LSB = (ch == 0) ? R_LSB : (ch == 1) ? G_LSB : B_LSB;
      localparam int W   = MSB - LSB + 1;

      logic [W-1:0] row_max [3];
      logic [W-1:0] row_mid [3];
      logic [W-1:0] row_min [3];
      logic [W-1:0] min_of_maxes, mid_of_mids, max_of_mins, median;
      logic [W-1:0] unused_s2 [6];
      logic [W-1:0] unused_s3 [2];

      // S1: sort each window row.
      for (genvar r = 0; r < 3; r++) begin : g_row
         sort3 #(.W(W)) u_row (
            .clk(clk), .rst_n(rst_n),
            .a(tap[3*r][MSB:LSB]), .b(tap[3*r+1][MSB:LSB]), .c(tap[3*r+2][MSB:LSB]),
            .max(row_max[r]), .mid(row_mid[r]), .min(row_min[r])
         );
      end

      // S2: the median lies between max-of-mins and min-of-maxes, near mid-of-mids.
      sort3 #(.W(W)) u_maxes (
         .clk(clk), .rst_n(rst_n),
         .a(row_max[0]), .b(row_max[1]), .c(row_max[2]),
         .max(unused_s2[0]), .mid(unused_s2[1]), .min(min_of_maxes)
      );
      sort3 #(.W(W)) u_mids (
         .clk(clk), .rst_n(rst_n),
         .a(row_mid[0]), .b(row_mid[1]), .c(row_mid[2]),
         .max(unused_s2[2]), .mid(mid_of_mids), .min(unused_s2[3])
      );
      sort3 #(.W(W)) u_mins (
         .clk(clk), .rst_n(rst_n),
         .a(row_min[0]), .b(row_min[1]), .c(row_min[2]),
         .max(max_of_mins), .mid(unused_s2[4]), .min(unused_s2[5])
      );

      // S3: median of the three candidates.
      sort3 #(.W(W)) u_final (
         .clk(clk), .rst_n(rst_n),
         .a(max_of_mins), .b(mid_of_mids), .c(min_of_maxes),
         .max(unused_s3[0]), .mid(median), .min(unused_s3[1])
      );

      assign median_dat[MSB:LSB] = median;
   end

   logic [MEDIAN_LATENCY-1:0] vsync_sr, hsync_sr, clken_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_sr <= '0;
         hsync_sr <= '0;
         clken_sr <= '0;
      end else begin
         vsync_sr <= {vsync_sr[MEDIAN_LATENCY-2:0], matrix_frame_vsync};
         hsync_sr <= {hsync_sr[MEDIAN_LATENCY-2:0], matrix_frame_hsync};
         clken_sr <= {clken_sr[MEDIAN_LATENCY-2:0], matrix_frame_clken};
      end
   end

   assign post_frame_vsync = vsync_sr[MEDIAN_LATENCY-1];
   assign post_frame_hsync = hsync_sr[MEDIAN_LATENCY-1];
   assign post_frame_clken = clken_sr[MEDIAN_LATENCY-1];

`ifdef MEDIAN_BORDER_PASS_EN
   localparam int CW = $clog2(IMG_HDISP + 1);
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP);

   logic [CW-1:0]             col;
   logic [MEDIAN_LATENCY-1:0] border_sr;
   logic [15:0]               centre_d0, centre_d1, centre_d2;

   // col counts valid pixels already seen in this line; the first two lack a full
   // horizontal window, so their raw centre is carried alongside the median.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         border_sr <= '0;
         centre_d0 <= '0;
         centre_d1 <= '0;
         centre_d2 <= '0;
      end else begin
         if (!matrix_frame_hsync)
            col <= '0;
         else if (matrix_frame_clken && col != COL_MAX)
            col <= col + 1'b1;
         border_sr <= {border_sr[MEDIAN_LATENCY-2:0], matrix_frame_clken && (col < CW'(2))};
         centre_d0 <= matrix_22;
         centre_d1 <= centre_d0;
         centre_d2 <= centre_d1;
      end
   end

   assign post_img_data = border_sr[MEDIAN_LATENCY-1] ? centre_d2 : median_dat;
`else
   assign post_img_data = median_dat;
`endif

endmodule

// File: tb/tb_median_filter_3x3_rgb565.sv
// Purpose: self-checking bench for median_filter_3x3_rgb565 (directed + random windows).
// Latency: expects every output 3 clk after the matching input.
// Backpressure: none exercised; the design has no ready path.
module tb_median_filter_3x3_rgb565;
   import median_pkg::*;

   localparam int HDISP = 640;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        vs = 1'b0, hs = 1'b0, ce = 1'b0;
   logic [15:0] tap [9];
   logic        post_vs, post_hs, post_ce;
   logic [15:0] post_dat;

   int checks = 0;
   int failures = 0;
   int model_col = 0;

   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        ce;
      logic [15:0] dat;
   } exp_t;

   exp_t exp_q [$];

   always #5 clk = ~clk;

   median_filter_3x3_rgb565 #(.IMG_HDISP(HDISP)) dut (
      .clk(clk), .rst_n(rst_n),
      .matrix_frame_vsync(vs), .matrix_frame_hsync(hs), .matrix_frame_clken(ce),
      .matrix_11(tap[0]), .matrix_12(tap[1]), .matrix_13(tap[2]),
      .matrix_21(tap[3]), .matrix_22(tap[4]), .matrix_23(tap[5]),
      .matrix_31(tap[6]), .matrix_32(tap[7]), .matrix_33(tap[8]),
      .post_frame_vsync(post_vs), .post_frame_hsync(post_hs), .post_frame_clken(post_ce),
      .post_img_data(post_dat)
   );

   // Median of nine values by full sort: middle element.
   function automatic int med9(input int v[9]);
      int t;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      return v[4];
   endfunction

   function automatic logic [15:0] model_median();
      int rv[9], gv[9], bv[9];
      rgb565_t px;
      for (int i = 0; i < 9; i++) begin
         rv[i] = int'(tap[i][R_MSB:R_LSB]);
         gv[i] = int'(tap[i][G_MSB:G_LSB]);
         bv[i] = int'(tap[i][B_MSB:B_LSB]);
      end
      px.r = r_chan_t'(med9(rv));
      px.g = g_chan_t'(med9(gv));
      px.b = b_chan_t'(med9(bv));
      return px;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < 9; i++) tap[i] = v;
   endtask

   task automatic set_rand();
      for (int i = 0; i < 9; i++) tap[i] = 16'($urandom);
   endtask

   // One clock: predict the output for the current inputs, advance, compare the
   // output due now (inputs from three edges earlier).
   task automatic cycle();
      exp_t e;
      e.vs  = vs;
      e.hs  = hs;
      e.ce  = ce;
      e.dat = model_median();
`ifdef MEDIAN_BORDER_PASS_EN
      if (ce && model_col < 2) e.dat = tap[4];
`endif
      if (!hs) model_col = 0;
      else if (ce && model_col < HDISP) model_col++;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("post_frame_vsync", {15'd0, post_vs}, {15'd0, e.vs});
      chk("post_frame_hsync", {15'd0, post_hs}, {15'd0, e.hs});
      chk("post_frame_clken", {15'd0, post_ce}, {15'd0, e.ce});
      chk("post_img_data", post_dat, e.dat);
   endtask

   // Reset for one clock; outputs must clear without waiting for an edge.
   task automatic reset_dut();
      exp_t z;
      z = '0;
      rst_n = 1'b0;
      #1;
      chk("reset_vsync", {15'd0, post_vs}, 16'd0);
      chk("reset_hsync", {15'd0, post_hs}, 16'd0);
      chk("reset_clken", {15'd0, post_ce}, 16'd0);
      chk("reset_data", post_dat, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(z);
      exp_q.push_back(z);
      model_col = 0;
   endtask

   initial begin
      logic [4:0] rvals [9];
      logic [5:0] gvals [9];
      rvals = '{5'd7, 5'd2, 5'd9, 5'd4, 5'd1, 5'd8, 5'd3, 5'd6, 5'd5};
      gvals = '{6'd63, 6'd0, 6'd63, 6'd0, 6'd63, 6'd0, 6'd63, 6'd0, 6'd63};

      set_all(16'h0000);
      #2;
      reset_dut();

      // Uniform window, continuous clken: first result exactly 3 clk later.
      hs = 1'b1; ce = 1'b1;
      set_all(16'hF800);
      repeat (6) cycle();
      chk("uniform_data", post_dat, 16'hF800);
      chk("uniform_clken", {15'd0, post_ce}, 16'd1);

      // Salt noise on the centre tap is rejected.
      set_all(16'h0841);
      tap[4] = 16'hFFFF;
      repeat (4) cycle();
      chk("salt_noise", post_dat, 16'h0841);

      // Channels filtered independently.
      for (int i = 0; i < 9; i++) tap[i] = {rvals[i], gvals[i], 5'd31};
      repeat (4) cycle();
      chk("channel_indep", post_dat, 16'h2FFF);

      // Sync alignment: vsync pulse, 10-cycle hsync with alternating clken.
      hs = 1'b0; ce = 1'b0;
      repeat (3) cycle();
      vs = 1'b1; cycle(); vs = 1'b0;
      hs = 1'b1;
      for (int i = 0; i < 10; i++) begin
         ce = (i % 2 == 0);
         set_rand();
         cycle();
      end
      hs = 1'b0; ce = 1'b0;
      repeat (4) cycle();

      // Start of line: two border pixels then an interior one.
      hs = 1'b1; ce = 1'b1;
      set_rand(); tap[4] = 16'h1234; cycle();
      set_rand(); tap[4] = 16'h5678; cycle();
      set_rand(); cycle();
      ce = 1'b0;
`ifdef MEDIAN_BORDER_PASS_EN
      chk("border_col0", post_dat, 16'h1234);
      cycle();
      chk("border_col1", post_dat, 16'h5678);
`else
      cycle();
`endif
      repeat (3) cycle();

      // Reset mid-line, then the line continues.
      ce = 1'b1;
      repeat (3) begin set_rand(); cycle(); end
      reset_dut();
      repeat (3) begin set_rand(); cycle(); end
      set_all(16'hF800);
      repeat (4) cycle();
      chk("after_reset", post_dat, 16'hF800);

      // Random lines: random lengths, clken gaps and window contents.
      for (int line = 0; line < 25; line++) begin
         vs = (line % 12 == 0);
         hs = 1'b0; ce = 1'b0;
         repeat ($urandom_range(1, 3)) begin set_rand(); cycle(); end
         vs = 1'b0;
         hs = 1'b1;
         repeat ($urandom_range(4, 20)) begin
            ce = ($urandom_range(0, 3) != 0);
            set_rand();
            cycle();
         end
      end
      hs = 1'b0; ce = 1'b0;
      repeat (4) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
